// File: rtl/ili9341_display_controller_pkg.sv
// Shared definitions for the ILI9341 controller: command opcodes, state codes,
// init/window ROM entry format and delay helpers.
package ili9341_display_controller_pkg;

  // Display command opcodes
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // Command parameters used by the init list
  localparam logic [7:0] COLMOD_RGB565         = 8'h55;
  localparam logic [7:0] MADCTL_LANDSCAPE_BGR  = 8'h28;

  // Status value reserved for "no status available" on the debug link
  localparam logic [31:0] INVALID_DISPLAY_STATUS = 32'hFFFF_FFFF;

  // Delay lengths in milliseconds
  localparam int unsigned RESET_LOW_MS  = 10;
  localparam int unsigned RESET_WAIT_MS = 120;
  localparam int unsigned SWRESET_MS    = 5;
  localparam int unsigned SLPOUT_MS     = 120;

  // Top-level state; the code is what appears on display_status
  typedef enum logic [7:0] {
    ST_RESET      = 8'h00,
    ST_RESET_WAIT = 8'h01,
    ST_INIT       = 8'h02,
    ST_WINDOW     = 8'h03,
    ST_FRAME      = 8'h04
  } state_e;

  // Byte-engine phase inside INIT / WINDOW / FRAME
  typedef enum logic [2:0] {
    PH_SEND,
    PH_PULSE,
    PH_SKIP,
    PH_WAIT,
    PH_DELAY,
    PH_MEM_REQ,
    PH_MEM_WAIT
  } phase_e;

  // Post-byte delay requested by a ROM entry
  typedef enum logic [1:0] {
    DLY_NONE,
    DLY_5MS,
    DLY_120MS
  } delay_e;

  typedef struct packed {
    logic       is_cmd;
    delay_e     dly;
    logic [7:0] data;
  } rom_entry_t;

  // ROM layout: init list first, window list right after it
  localparam logic [4:0] ROM_INIT_START   = 5'd0;
  localparam logic [4:0] ROM_WINDOW_START = 5'd7;

  function automatic logic [31:0] ms_to_cycles(input int unsigned freq_hz,
                                               input int unsigned ms);
    return 32'(freq_hz / 1000 * ms);
  endfunction

  function automatic rom_entry_t rom_cmd(input logic [7:0] op, input delay_e dly);
    return '{is_cmd: 1'b1, dly: dly, data: op};
  endfunction

  function automatic rom_entry_t rom_data(input logic [7:0] b);
    return '{is_cmd: 1'b0, dly: DLY_NONE, data: b};
  endfunction

endpackage

// File: rtl/ili9341_display_controller_if.sv
// Bundle of the SPI-master, frame-memory and display-pin signals. The
// controller uses the master modport; the SPI core, memory and pads see slave.
interface ili9341_display_controller_if;
  logic        spi_busy;
  logic [7:0]  spi_in;
  logic        spi_start;
  logic [7:0]  spi_out;
  logic [7:0]  mem_in;
  logic        mem_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        dis_reset;
  logic        dc;
  logic        cs;

  modport master (
    input  spi_busy, spi_in, mem_in, mem_ready,
    output spi_start, spi_out, mem_req, mem_addr, dis_reset, dc, cs
  );

  modport slave (
    output spi_busy, spi_in, mem_in, mem_ready,
    input  spi_start, spi_out, mem_req, mem_addr, dis_reset, dc, cs
  );
endinterface

// File: rtl/ili9341_display_controller_init_rom.sv
// Command/data byte list for display bring-up and for the per-frame address
// window. Each entry carries its D/C flag and an optional trailing delay;
// last_o marks the final entry of the init list and of the window list.
module ili9341_display_controller_init_rom
  import ili9341_display_controller_pkg::*;
#(
  parameter int unsigned DIS_RES_X = 320,
  parameter int unsigned DIS_RES_Y = 240
) (
  input  logic [4:0] idx_i,
  output rom_entry_t entry_o,
  output logic       last_o
);

  localparam logic [15:0] X_MAX = 16'(DIS_RES_X - 1);
  localparam logic [15:0] Y_MAX = 16'(DIS_RES_Y - 1);

  // Index decode into the byte list
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    entry_o = rom_data(8'h00);
    last_o  = 1'b0;
    case (idx_i)
      5'd0:  entry_o = rom_cmd(CMD_SWRESET, DLY_5MS);
      5'd1:  entry_o = rom_cmd(CMD_SLPOUT, DLY_120MS);
      5'd2:  entry_o = rom_cmd(CMD_COLMOD, DLY_NONE);
      5'd3:  entry_o = rom_data(COLMOD_RGB565);
      5'd4:  entry_o = rom_cmd(CMD_MADCTL, DLY_NONE);
      5'd5:  entry_o = rom_data(MADCTL_LANDSCAPE_BGR);
      5'd6:  begin
        entry_o = rom_cmd(CMD_DISPON, DLY_NONE);
        last_o  = 1'b1;
      end
      5'd7:  entry_o = rom_cmd(CMD_CASET, DLY_NONE);
      5'd8:  entry_o = rom_data(8'h00);
      5'd9:  entry_o = rom_data(8'h00);
      5'd10: entry_o = rom_data(X_MAX[15:8]);
      5'd11: entry_o = rom_data(X_MAX[7:0]);
      5'd12: entry_o = rom_cmd(CMD_PASET, DLY_NONE);
      5'd13: entry_o = rom_data(8'h00);
      5'd14: entry_o = rom_data(8'h00);
      5'd15: entry_o = rom_data(Y_MAX[15:8]);
      5'd16: entry_o = rom_data(Y_MAX[7:0]);
      5'd17: begin
        entry_o = rom_cmd(CMD_RAMWR, DLY_NONE);
        last_o  = 1'b1;
      end
      // Unused indices terminate the list so a stray index cannot run away
      default: last_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ili9341_display_controller.sv
// ILI9341 controller: hardware reset pulse, init command list, then an endless
// loop of address-window setup followed by a full frame streamed byte-wise
// from the frame memory into the byte-level SPI master.
module ili9341_display_controller
  import ili9341_display_controller_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 12_000_000,
  parameter int unsigned DIS_RES_X    = 320,
  parameter int unsigned DIS_RES_Y    = 240
) (
  input  logic                                clk,
  input  logic                                reset,
  ili9341_display_controller_if.master        dsp_if,
  output logic [7:0]                          spi_rx_o,
  output logic [31:0]                         display_status_o
);

  localparam logic [31:0] CYC_RESET_LOW  = ms_to_cycles(SYS_CLK_FREQ, RESET_LOW_MS);
  localparam logic [31:0] CYC_RESET_WAIT = ms_to_cycles(SYS_CLK_FREQ, RESET_WAIT_MS);
  localparam logic [31:0] CYC_SWRESET    = ms_to_cycles(SYS_CLK_FREQ, SWRESET_MS);
  localparam logic [31:0] CYC_SLPOUT     = ms_to_cycles(SYS_CLK_FREQ, SLPOUT_MS);
  localparam int unsigned FRAME_BYTES    = DIS_RES_X * DIS_RES_Y * 2;
  localparam logic [31:0] LAST_ADDR      = 32'(FRAME_BYTES - 1);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  rx_q, rx_d;
  logic        dis_reset_q, dis_reset_d;
  logic        dc_q, dc_d;
  logic        cs_q, cs_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_out_q, spi_out_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  rom_entry_t  rom_entry;
  logic        rom_last;
  logic        in_frame;
  logic        advance;

  ili9341_display_controller_init_rom #(
    .DIS_RES_X (DIS_RES_X),
    .DIS_RES_Y (DIS_RES_Y)
  ) u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry),
    .last_o  (rom_last)
  );

  assign in_frame = (state_q == ST_FRAME);

  // State and output registers; synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= ST_RESET;
      phase_q     <= PH_SEND;
      idx_q       <= ROM_INIT_START;
      cnt_q       <= CYC_RESET_LOW - 32'd1;
      data_q      <= '0;
      rx_q        <= '0;
      dis_reset_q <= 1'b0;
      dc_q        <= 1'b0;
      cs_q        <= 1'b1;
      spi_start_q <= 1'b0;
      spi_out_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      rx_q        <= rx_d;
      dis_reset_q <= dis_reset_d;
      dc_q        <= dc_d;
      cs_q        <= cs_d;
      spi_start_q <= spi_start_d;
      spi_out_q   <= spi_out_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Next-state logic: reset delays, then the shared byte engine for ROM and frame bytes
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rx_d        = rx_q;
    dis_reset_d = dis_reset_q;
    dc_d        = dc_q;
    cs_d        = cs_q;
    spi_start_d = 1'b0;
    spi_out_d   = spi_out_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    advance     = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        dis_reset_d = 1'b0;
        cs_d        = 1'b1;
        if (cnt_q == '0) begin
          state_d     = ST_RESET_WAIT;
          dis_reset_d = 1'b1;
          cnt_d       = CYC_RESET_WAIT - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      ST_RESET_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_INIT;
          cs_d    = 1'b0;
          phase_d = PH_SEND;
          idx_d   = ROM_INIT_START;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      ST_INIT, ST_WINDOW, ST_FRAME: begin
        unique case (phase_q)
          // Only fetch the next pixel byte once the SPI master is idle
          PH_MEM_REQ: begin
            if (!dsp_if.spi_busy) begin
              mem_req_d = 1'b1;
              phase_d   = PH_MEM_WAIT;
            end
          end
          // The request pulse cycle itself cannot carry the answer
          PH_MEM_WAIT: begin
            if (dsp_if.mem_ready && !mem_req_q) begin
              data_d  = dsp_if.mem_in;
              phase_d = PH_SEND;
            end
          end
          PH_SEND: begin
            if (!dsp_if.spi_busy) begin
              spi_start_d = 1'b1;
              spi_out_d   = in_frame ? data_q : rom_entry.data;
              dc_d        = in_frame ? 1'b1 : !rom_entry.is_cmd;
              phase_d     = PH_PULSE;
            end
          end
          // Give the SPI master time to raise busy before watching it
          PH_PULSE: phase_d = PH_SKIP;
          PH_SKIP:  phase_d = PH_WAIT;
          PH_WAIT: begin
            if (!dsp_if.spi_busy) begin
              rx_d = dsp_if.spi_in;
              if (!in_frame && rom_entry.dly != DLY_NONE) begin
                cnt_d   = ((rom_entry.dly == DLY_120MS) ? CYC_SLPOUT : CYC_SWRESET) - 32'd1;
                phase_d = PH_DELAY;
              end else begin
                advance = 1'b1;
              end
            end
          end
          PH_DELAY: begin
            if (cnt_q == '0) begin
              advance = 1'b1;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
          default: phase_d = PH_SEND;
        endcase

        // Step to the next byte, list or frame once the current byte is done
        if (advance) begin
          if (in_frame) begin
            if (mem_addr_q == LAST_ADDR) begin
              mem_addr_d = '0;
              state_d    = ST_WINDOW;
              idx_d      = ROM_WINDOW_START;
              phase_d    = PH_SEND;
            end else begin
              mem_addr_d = mem_addr_q + 32'd1;
              phase_d    = PH_MEM_REQ;
            end
          end else if (rom_last) begin
            if (state_q == ST_INIT) begin
              state_d = ST_WINDOW;
              idx_d   = ROM_WINDOW_START;
              phase_d = PH_SEND;
            end else begin
              state_d    = ST_FRAME;
              mem_addr_d = '0;
              phase_d    = PH_MEM_REQ;
            end
          end else begin
            idx_d   = idx_q + 5'd1;
            phase_d = PH_SEND;
          end
        end
      end

      default: state_d = ST_RESET;
    endcase
  end

  assign dsp_if.dis_reset = dis_reset_q;
  assign dsp_if.dc        = dc_q;
  assign dsp_if.cs        = cs_q;
  assign dsp_if.spi_start = spi_start_q;
  assign dsp_if.spi_out   = spi_out_q;
  assign dsp_if.mem_req   = mem_req_q;
  assign dsp_if.mem_addr  = mem_addr_q;
  assign spi_rx_o         = rx_q;
  // Status follows the registered state, so it only moves on transitions
  assign display_status_o = {24'h0, state_q};

endmodule

// File: tb/tb_ili9341_display_controller.sv
// Directed bench for the ILI9341 controller with a small SPI-master model
// (8 busy cycles per byte) and a memory model (3-cycle latency, data=addr[7:0]).
// Runs at 1 kHz so one millisecond is one clock; a 300x2 frame keeps it short.
module tb_ili9341_display_controller;
  import ili9341_display_controller_pkg::*;

  localparam int unsigned SYS_HZ = 1000;
  localparam int unsigned RES_X  = 300;
  localparam int unsigned RES_Y  = 2;
  localparam int          NBYTES = 1200;   // 300*2*2
  localparam int          F2     = 1229;   // log index of first byte of frame 2

  logic        clk;
  logic        reset;
  logic [7:0]  spi_rx;
  logic [31:0] display_status;

  ili9341_display_controller_if bus ();

  ili9341_display_controller #(
    .SYS_CLK_FREQ (SYS_HZ),
    .DIS_RES_X    (RES_X),
    .DIS_RES_Y    (RES_Y)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .dsp_if           (bus),
    .spi_rx_o         (spi_rx),
    .display_status_o (display_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SPI master model
  logic [3:0]  busy_cnt;
  logic        hold_busy;
  int          cyc = 0;
  int          start_viol = 0;
  logic [8:0]  byte_log[$];
  int          stamp_log[$];

  assign bus.spi_busy = (busy_cnt != 4'd0) || hold_busy;
  assign bus.spi_in   = 8'hA5;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      busy_cnt <= 4'd0;
    end else begin
      if (bus.spi_start && busy_cnt != 4'd0) start_viol <= start_viol + 1;
      if (bus.spi_start && busy_cnt == 4'd0) begin
        busy_cnt <= 4'd8;
        byte_log.push_back({bus.dc, bus.spi_out});
        stamp_log.push_back(cyc);
      end else if (busy_cnt != 4'd0) begin
        busy_cnt <= busy_cnt - 4'd1;
      end
    end
  end

  // Memory model
  logic [1:0]  lat;
  logic [31:0] lat_addr;
  logic        model_ready;
  logic [7:0]  model_data;
  logic        stray_ready;
  int          req_viol = 0;
  logic [31:0] addr_log[$];

  assign bus.mem_ready = model_ready || stray_ready;
  assign bus.mem_in    = stray_ready ? 8'hEE : model_data;

  always @(posedge clk) begin
    if (reset) begin
      lat         <= 2'd0;
      model_ready <= 1'b0;
      model_data  <= 8'h00;
      lat_addr    <= '0;
    end else begin
      model_ready <= 1'b0;
      if (bus.mem_req) begin
        if (lat != 2'd0 || model_ready) req_viol <= req_viol + 1;
        lat      <= 2'd3;
        lat_addr <= bus.mem_addr;
        addr_log.push_back(bus.mem_addr);
      end else if (lat != 2'd0) begin
        lat <= lat - 2'd1;
        if (lat == 2'd1) begin
          model_ready <= 1'b1;
          model_data  <= lat_addr[7:0];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dis_reset"}, {31'd0, bus.dis_reset}, 32'd0);
    check({tag, "_dc"},        {31'd0, bus.dc},        32'd0);
    check({tag, "_cs"},        {31'd0, bus.cs},        32'd1);
    check({tag, "_spi_start"}, {31'd0, bus.spi_start}, 32'd0);
    check({tag, "_spi_out"},   {24'd0, bus.spi_out},   32'd0);
    check({tag, "_mem_req"},   {31'd0, bus.mem_req},   32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr,           32'd0);
    check({tag, "_status"},    display_status,         32'h0000_0000);
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (byte_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, byte_log.size() >= n}, 32'd1);
  endtask

  logic [8:0] exp_seq [18];
  int n;
  int pre;
  int g;

  initial begin
    exp_seq = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h128, 9'h029,
                9'h02A, 9'h100, 9'h100, 9'h101, 9'h12B,
                9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
    reset       = 1'b1;
    hold_busy   = 1'b0;
    stray_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");

    // Hardware reset pulse and power-up wait
    reset = 1'b0;
    n = 0;
    while (bus.dis_reset === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    check("dis_reset_low_cycles", n, 10);
    check("status_reset_wait", display_status, 32'h0000_0001);
    n = 0;
    while (bus.cs === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    check("cs_high_cycles", n, 120);
    check("status_init", display_status, 32'h0000_0002);

    // A mem_ready with nothing outstanding must be ignored
    stray_ready = 1'b1;
    @(negedge clk);
    stray_ready = 1'b0;

    // Init list and first window
    wait_log(18, 5000, "init_window_timeout");
    for (int i = 0; i < 18; i++) check($sformatf("seq[%0d]", i), {23'd0, byte_log[i]}, {23'd0, exp_seq[i]});
    g = stamp_log[1] - stamp_log[0];
    check("gap_after_swreset", {31'd0, (g >= 13 && g <= 30)}, 32'd1);
    g = stamp_log[2] - stamp_log[1];
    check("gap_after_slpout", {31'd0, (g >= 128 && g <= 150)}, 32'd1);
    g = stamp_log[3] - stamp_log[2];
    check("gap_no_delay", {31'd0, (g < 13)}, 32'd1);

    // Full frame, then the window sequence starts again
    wait_log(18 + NBYTES + 1, 30000, "frame_timeout");
    for (int i = 0; i < NBYTES; i++) begin
      check($sformatf("frame_byte[%0d]", i), {23'd0, byte_log[18 + i]}, {23'd0, 1'b1, 8'(i)});
      check($sformatf("frame_addr[%0d]", i), addr_log[i], 32'(i));
    end
    check("rewindow_caset", {23'd0, byte_log[18 + NBYTES]}, 32'h0000_002A);
    check("status_window", display_status, 32'h0000_0003);
    check("status_not_invalid", {31'd0, display_status !== INVALID_DISPLAY_STATUS}, 32'd1);

    // Into the second frame, then stall the SPI master
    wait_log(F2 + 5, 2000, "frame2_timeout");
    check("status_frame", display_status, 32'h0000_0004);
    hold_busy = 1'b1;
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (bus.spi_start === 1'b1 || bus.mem_req === 1'b1) n++;
      @(negedge clk);
    end
    hold_busy = 1'b0;
    check("pulses_during_busy_hold", n, 0);
    pre = byte_log.size();
    wait_log(pre + 3, 500, "resume_timeout");
    for (int k = pre; k < pre + 3; k++)
      check($sformatf("frame2_byte[%0d]", k - F2), {23'd0, byte_log[k]}, {23'd0, 1'b1, 8'(k - F2)});
    for (int k = NBYTES; k < addr_log.size(); k++)
      check($sformatf("frame2_addr[%0d]", k - NBYTES), addr_log[k], 32'(k - NBYTES));
    check("spi_start_while_busy", start_viol, 0);
    check("mem_req_while_pending", req_viol, 0);

    // Reset in the middle of a frame restarts the whole sequence
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (bus.dis_reset === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    check("restart_dis_reset_low_cycles", n, 10);
    pre = byte_log.size();
    wait_log(pre + 1, 1000, "restart_timeout");
    check("restart_first_byte", {23'd0, byte_log[pre]}, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
